mux_l2: RTL and testbench

- Layer-2 merge block: takes two independent 8-bit valid-qualified byte streams and combines them into a single output stream.
- Each input lane has a small FIFO. A round-robin arbiter picks one lane per cycle.
- The output carries a lane tag, so a downstream demuxL2 can split the stream back using that tag as its selector.
- Sits upstream of the demux layer, as the transmit-side counterpart in the L2 datapath.

---
 rtl/mux_l2_pkg.sv | 24 ++
 rtl/mux_l2_if.sv | 26 ++
 rtl/mux_l2_fifo.sv | 72 +++++++
 rtl/mux_l2.sv | 107 ++++++++++
 tb/tb_mux_l2.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mux_l2_pkg.sv
// rtl/mux_l2_pkg.sv - shared parameters, lane enum and pointer-width helper for mux_l2
package mux_l2_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    // Smallest r with 2**r >= value; constant-foldable for parameter use.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_l2_if.sv
// rtl/mux_l2_if.sv - lane inputs and merged output bundle for mux_l2
interface mux_l2_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Entrada0;
    logic             validEntrada0;
    logic [WIDTH-1:0] Entrada1;
    logic             validEntrada1;
    logic [WIDTH-1:0] Salida;
    logic             validSalida;
    logic             selector;
    logic             full0;
    logic             full1;
    logic             overflow0;
    logic             overflow1;

    modport slave (
        input  Entrada0, validEntrada0, Entrada1, validEntrada1,
        output Salida, validSalida, selector, full0, full1, overflow0, overflow1
    );

    modport master (
        output Entrada0, validEntrada0, Entrada1, validEntrada1,
        input  Salida, validSalida, selector, full0, full1, overflow0, overflow1
    );
endinterface

// File: rtl/mux_l2_fifo.sv
// rtl/mux_l2_fifo.sv - per-lane synchronous FIFO with combinational head read
module fifo_l2
    import mux_l2_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = clog2_f(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come from the pre-edge count, so a same-edge pop never frees a slot for the push.
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/mux_l2.sv
// rtl/mux_l2.sv - two-lane round-robin merge with lane tag on the output
module mux_l2
    import mux_l2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic   clk,
    input  logic   reset,
    mux_l2_if.slave bus
);

    localparam int             PTR_W    = clog2_f(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] head0, head1;
    logic [PTR_W:0]   cnt0, cnt1;
    logic             full0, full1;
    logic             empty0, empty1;

    logic             gnt_vld;
    lane_e            gnt_lane;
    lane_e            last_q, last_d;
    logic [WIDTH-1:0] salida_q, salida_d;
    lane_e            sel_q, sel_d;
    logic             valid_q;
    logic             ovf0_q, ovf0_d;
    logic             ovf1_q, ovf1_d;

    fifo_l2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (bus.validEntrada0),
        .din_i   (bus.Entrada0),
        .pop_i   (gnt_vld && (gnt_lane == LANE0)),
        .dout_o  (head0),
        .count_o (cnt0),
        .full_o  (full0),
        .empty_o (empty0)
    );

    fifo_l2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (bus.validEntrada1),
        .din_i   (bus.Entrada1),
        .pop_i   (gnt_vld && (gnt_lane == LANE1)),
        .dout_o  (head1),
        .count_o (cnt1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    // On a tie the lane that did not win last time goes; a lone requester still moves last_q.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_lane = LANE0;
        if (!empty0 && !empty1) begin
            gnt_vld  = 1'b1;
            gnt_lane = (last_q == LANE1) ? LANE0 : LANE1;
        end else if (!empty0) begin
            gnt_vld  = 1'b1;
            gnt_lane = LANE0;
        end else if (!empty1) begin
            gnt_vld  = 1'b1;
            gnt_lane = LANE1;
        end

        last_d   = gnt_vld ? gnt_lane : last_q;
        salida_d = salida_q;
        sel_d    = sel_q;
        if (gnt_vld) begin
            salida_d = (gnt_lane == LANE0) ? head0 : head1;
            sel_d    = gnt_lane;
        end

        ovf0_d = ovf0_q || (bus.validEntrada0 && (cnt0 == FULL_CNT));
        ovf1_d = ovf1_q || (bus.validEntrada1 && (cnt1 == FULL_CNT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q   <= LANE1;
            salida_q <= '0;
            sel_q    <= LANE0;
            valid_q  <= 1'b0;
            ovf0_q   <= 1'b0;
            ovf1_q   <= 1'b0;
        end else begin
            last_q   <= last_d;
            salida_q <= salida_d;
            sel_q    <= sel_d;
            valid_q  <= gnt_vld;
            ovf0_q   <= ovf0_d;
            ovf1_q   <= ovf1_d;
        end
    end

    assign bus.Salida      = salida_q;
    assign bus.validSalida = valid_q;
    assign bus.selector    = sel_q;
    assign bus.full0       = full0;
    assign bus.full1       = full1;
    assign bus.overflow0   = ovf0_q;
    assign bus.overflow1   = ovf1_q;

endmodule

// File: tb/tb_mux_l2.sv
// tb/tb_mux_l2.sv - directed self-checking bench for mux_l2
module tb_mux_l2;
    import mux_l2_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mux_l2_if #(.WIDTH(WIDTH_DEF)) bus ();

    mux_l2 #(.WIDTH(WIDTH_DEF), .DEPTH(DEPTH_DEF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected drain order for the fill/overflow run, edges 2..19.
    logic [7:0] fill_exp [18] = '{
        8'h00, 8'h80, 8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04,
        8'h84, 8'h05, 8'h85, 8'h06, 8'h87, 8'h08, 8'h89, 8'h0A, 8'h8B
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        bus.validEntrada0 = v0;
        bus.Entrada0      = d0;
        bus.validEntrada1 = v1;
        bus.Entrada1      = d1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic s);
        check({tag, "_valid"}, 32'(bus.validSalida), 32'd1);
        check({tag, "_data"},  32'(bus.Salida), 32'(d));
        check({tag, "_sel"},   32'(bus.selector), 32'(s));
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        check("rst_valid", 32'(bus.validSalida), 32'd0);
        check("rst_data",  32'(bus.Salida), 32'd0);
        check("rst_sel",   32'(bus.selector), 32'd0);
        check("rst_full",  32'({bus.full0, bus.full1}), 32'd0);
        check("rst_ovf",   32'({bus.overflow0, bus.overflow1}), 32'd0);

        // Reset with bytes buffered: nothing may leak out afterwards.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h40 + 8'(i), 1'b1, 8'h50 + 8'(i));
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        check("buf_pre_valid", 32'(bus.validSalida), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("buf_rst_valid", 32'(bus.validSalida), 32'd0);
        check("buf_rst_data",  32'(bus.Salida), 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", 32'(bus.validSalida), 32'd0);
        end
        check("idle_full", 32'({bus.full0, bus.full1}), 32'd0);

        // Single lane, back-to-back bytes, one-cycle latency.
        drive(1'b1, 8'h11, 1'b0, 8'h00);
        tick();
        check("single_lat", 32'(bus.validSalida), 32'd0);
        drive(1'b1, 8'h22, 1'b0, 8'h00);
        tick();
        expect_out("single0", 8'h11, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 8'h00);
        tick();
        expect_out("single1", 8'h22, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        expect_out("single2", 8'h33, 1'b0);
        tick();
        check("single_end", 32'(bus.validSalida), 32'd0);
        check("single_hold", 32'(bus.Salida), 32'h33);

        // Tie after reset: lane 0 first, then strict alternation.
        do_reset();
        drive(1'b1, 8'hA0, 1'b1, 8'hB0);
        tick();
        drive(1'b1, 8'hA1, 1'b1, 8'hB1);
        tick();
        expect_out("tie0", 8'hA0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        expect_out("tie1", 8'hB0, 1'b1);
        tick();
        expect_out("tie2", 8'hA1, 1'b0);
        tick();
        expect_out("tie3", 8'hB1, 1'b1);
        tick();
        check("tie_end", 32'(bus.validSalida), 32'd0);

        // Wrap-around on lane 1 with idle gaps.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'hC0 + 8'(i));
            tick();
            drive(1'b0, 8'h00, 1'b0, 8'h00);
            tick();
            expect_out("wrap", 8'hC0 + 8'(i), 1'b1);
            check("wrap_full1", 32'(bus.full1), 32'd0);
        end
        check("wrap_ovf1", 32'(bus.overflow1), 32'd0);

        // Fill and overflow: both lanes valid for 12 edges.
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            if (e <= 12) begin
                drive(1'b1, 8'(e - 1), 1'b1, 8'h80 + 8'(e - 1));
            end else begin
                drive(1'b0, 8'h00, 1'b0, 8'h00);
            end
            tick();
            if (e >= 2 && e <= 19) begin
                expect_out("fill", fill_exp[e - 2], fill_exp[e - 2][7]);
            end else begin
                check("fill_idle", 32'(bus.validSalida), 32'd0);
            end
            if (e == 6) begin
                check("fill_full_e6", 32'({bus.full0, bus.full1}), 32'b01);
            end
            if (e == 7) begin
                check("fill_full_e7", 32'({bus.full0, bus.full1}), 32'b10);
                check("fill_ovf_e7",  32'({bus.overflow0, bus.overflow1}), 32'b01);
            end
        end
        check("fill_ovf_end", 32'({bus.overflow0, bus.overflow1}), 32'b11);

        // Async reset in the middle of an output burst.
        drive(1'b1, 8'h61, 1'b1, 8'h71);
        tick();
        drive(1'b1, 8'h62, 1'b1, 8'h72);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        check("burst_valid", 32'(bus.validSalida), 32'd1);
        check("burst_data",  32'(bus.Salida), 32'h61);
        #3;
        reset = 1'b0;
        #1;
        check("async_valid", 32'(bus.validSalida), 32'd0);
        check("async_data",  32'(bus.Salida), 32'd0);
        check("async_sel",   32'(bus.selector), 32'd0);
        check("async_ovf",   32'({bus.overflow0, bus.overflow1}), 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("async_idle", 32'(bus.validSalida), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
